// File: rtl/gshare_branch_tracker_if.sv
// Fetch/execute and gshare predict/train signal bundle.
// master drives fetch, resolve and predictor responses; slave is the tracker.
interface gshare_branch_tracker_if #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int CNT_W  = 16
);
  logic              br_valid;
  logic [PC_W-1:0]   br_pc;
  logic              br_ready;
  logic              br_pred_taken;
  logic              res_valid;
  logic              res_taken;
  logic              res_ready;
  logic              predict_valid;
  logic [PC_W-1:0]   predict_pc;
  logic              predict_taken;
  logic [HIST_W-1:0] predict_history;
  logic              train_valid;
  logic              train_taken;
  logic              train_mispredicted;
  logic [HIST_W-1:0] train_history;
  logic [PC_W-1:0]   train_pc;
  logic              flush;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output br_valid, br_pc, res_valid, res_taken,
    output predict_taken, predict_history,
    input  br_ready, br_pred_taken, res_ready,
    input  predict_valid, predict_pc,
    input  train_valid, train_taken, train_mispredicted,
    input  train_history, train_pc, flush,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  br_valid, br_pc, res_valid, res_taken,
    input  predict_taken, predict_history,
    output br_ready, br_pred_taken, res_ready,
    output predict_valid, predict_pc,
    output train_valid, train_taken, train_mispredicted,
    output train_history, train_pc, flush,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/gshare_branch_tracker.sv
// In-order in-flight branch queue between fetch/execute and gshare.
// Issues predicts, pairs resolves with entries, emits train and flush.
module gshare_branch_tracker #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic areset,
  gshare_branch_tracker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [HIST_W-1:0] hist;
    logic              taken;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              tv_q, tv_d;
  logic              tt_q, tt_d;
  logic              tm_q, tm_d;
  logic [HIST_W-1:0] th_q, th_d;
  logic [PC_W-1:0]   tp_q, tp_d;
  logic              fl_q, fl_d;
  logic [CNT_W-1:0]  bc_q, bc_d;
  logic [CNT_W-1:0]  mc_q, mc_d;

  entry_t head_e;
  logic   push, pop, mis, store;

  assign head_e = mem_q[head_q];
  assign push   = bus.br_valid && (cnt_q != FULL);
  assign pop    = bus.res_valid && (cnt_q != '0);
  assign mis    = pop && (bus.res_taken != head_e.taken);
  assign store  = push && !mis;

  assign bus.br_ready           = cnt_q != FULL;
  assign bus.res_ready          = cnt_q != '0;
  assign bus.predict_valid      = push;
  assign bus.predict_pc         = bus.br_pc;
  assign bus.br_pred_taken      = bus.predict_taken;
  assign bus.train_valid        = tv_q;
  assign bus.train_taken        = tt_q;
  assign bus.train_mispredicted = tm_q;
  assign bus.train_history      = th_q;
  assign bus.train_pc           = tp_q;
  assign bus.flush              = fl_q;
  assign bus.branch_cnt         = bc_q;
  assign bus.mispred_cnt        = mc_q;

  // Next-state for pointers, count, train bundle and statistics.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    tv_d   = pop;
    fl_d   = mis;
    tt_d   = tt_q;
    tm_d   = tm_q;
    th_d   = th_q;
    tp_d   = tp_q;
    bc_d   = bc_q;
    mc_d   = mc_q;
    if (pop) begin
      tt_d = bus.res_taken;
      tm_d = mis;
      th_d = head_e.hist;
      tp_d = head_e.pc;
      if (bc_q != CMAX) bc_d = bc_q + 1'b1;
      if (mis && mc_q != CMAX) mc_d = mc_q + 1'b1;
    end
    if (mis) begin
      head_d = tail_q;
      cnt_d  = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Control and train registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (areset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      tv_q   <= 1'b0;
      tt_q   <= 1'b0;
      tm_q   <= 1'b0;
      th_q   <= '0;
      tp_q   <= '0;
      fl_q   <= 1'b0;
      bc_q   <= '0;
      mc_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      tv_q   <= tv_d;
      tt_q   <= tt_d;
      tm_q   <= tm_d;
      th_q   <= th_d;
      tp_q   <= tp_d;
      fl_q   <= fl_d;
      bc_q   <= bc_d;
      mc_q   <= mc_d;
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (store && !areset) begin
      mem_q[tail_q] <= '{pc: bus.br_pc,
                         hist: bus.predict_history,
                         taken: bus.predict_taken};
    end
  end
endmodule

// File: tb/tb_gshare_branch_tracker.sv
// Randomized and directed checks of gshare_branch_tracker
// against a queue-based model of in-flight branches.
module tb_gshare_branch_tracker;
  localparam int DEPTH  = 8;
  localparam int PC_W   = 7;
  localparam int HIST_W = 7;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  gshare_branch_tracker_if #(
    .PC_W(PC_W), .HIST_W(HIST_W), .CNT_W(CNT_W)
  ) bus ();

  gshare_branch_tracker #(
    .DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .areset(areset),
    .bus(bus)
  );

  typedef struct {
    int pc;
    int h;
    int t;
  } ent_t;

  ent_t q[$];
  int m_tv, m_tt, m_tm, m_th, m_tp, m_fl, m_bc, m_mc;
  int total = 0;
  int bad = 0;
  int pv_seen;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int rst, input int bv, input int pc,
                            input int pt, input int ph,
                            input int rv, input int rt);
    int push, pop, mis;
    ent_t e;
    if (rst != 0) begin
      q.delete();
      m_tv = 0; m_tt = 0; m_tm = 0; m_th = 0;
      m_tp = 0; m_fl = 0; m_bc = 0; m_mc = 0;
      return;
    end
    push = (bv != 0) && (q.size() < DEPTH);
    pop  = (rv != 0) && (q.size() > 0);
    mis  = 0;
    m_tv = pop;
    m_fl = 0;
    if (pop) begin
      e = q.pop_front();
      mis = (rt != e.t);
      m_tp = e.pc; m_th = e.h; m_tt = rt; m_tm = mis;
      if (m_bc < CMAX) m_bc++;
      if (mis) begin
        if (m_mc < CMAX) m_mc++;
        m_fl = 1;
        q.delete();
      end
    end
    if (push && !mis) begin
      e.pc = pc; e.h = ph; e.t = pt;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input int rst, input int bv, input int pc,
                     input int pt, input int ph,
                     input int rv, input int rt);
    int full;
    @(negedge clk);
    areset = rst[0];
    bus.br_valid = bv[0];
    bus.br_pc = pc[PC_W-1:0];
    bus.predict_taken = pt[0];
    bus.predict_history = ph[HIST_W-1:0];
    bus.res_valid = rv[0];
    bus.res_taken = rt[0];
    #1;
    pv_seen = bus.predict_valid;
    if (rst == 0) begin
      full = (q.size() == DEPTH);
      chk("br_ready", bus.br_ready, !full);
      chk("res_ready", bus.res_ready, q.size() != 0);
      chk("predict_valid", bus.predict_valid, bv != 0 && !full);
      chk("predict_pc", bus.predict_pc, pc % (1 << PC_W));
      chk("br_pred_taken", bus.br_pred_taken, pt % 2);
    end
    @(posedge clk);
    model_step(rst, bv, pc % (1 << PC_W), pt % 2, ph % (1 << HIST_W),
               rv, rt % 2);
    #1;
    chk("train_valid", bus.train_valid, m_tv);
    chk("flush", bus.flush, m_fl);
    chk("train_taken", bus.train_taken, m_tt);
    chk("train_mis", bus.train_mispredicted, m_tm);
    chk("train_history", bus.train_history, m_th);
    chk("train_pc", bus.train_pc, m_tp);
    chk("branch_cnt", bus.branch_cnt, m_bc);
    chk("mispred_cnt", bus.mispred_cnt, m_mc);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.br_valid = 1'b0;
    bus.br_pc = '0;
    bus.predict_taken = 1'b0;
    bus.predict_history = '0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;

    // Reset state.
    rst_cyc();
    #1;
    chk("rst_br_ready", bus.br_ready, 1);
    chk("rst_res_ready", bus.res_ready, 0);
    chk("rst_train_valid", bus.train_valid, 0);

    // Single mispredicted branch.
    cyc(0, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t1_tv", bus.train_valid, 1);
    chk("t1_pc", bus.train_pc, 3);
    chk("t1_hist", bus.train_history, 0);
    chk("t1_taken", bus.train_taken, 1);
    chk("t1_mis", bus.train_mispredicted, 1);
    chk("t1_flush", bus.flush, 1);
    idle();
    chk("t1_res_ready", bus.res_ready, 0);
    chk("t1_bc", bus.branch_cnt, 1);
    chk("t1_mc", bus.mispred_cnt, 1);
    chk("t1_tv_drop", bus.train_valid, 0);

    // Fill to capacity, then drain in order.
    rst_cyc();
    for (int i = 0; i < 8; i++) cyc(0, 1, i, 1, i + 16, 0, 0);
    #1;
    chk("t2_full_ready", bus.br_ready, 0);
    cyc(0, 1, 9, 1, 0, 0, 0);
    chk("t2_ninth_pv", pv_seen, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("t2_tv", bus.train_valid, 1);
      chk("t2_pc", bus.train_pc, i);
      chk("t2_hist", bus.train_history, i + 16);
      chk("t2_mis", bus.train_mispredicted, 0);
    end
    idle();
    chk("t2_empty", bus.res_ready, 0);

    // Mispredict flushes younger entries; next resolve ignored.
    rst_cyc();
    for (int i = 1; i <= 3; i++) cyc(0, 1, i, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t3_pc", bus.train_pc, 1);
    chk("t3_flush", bus.flush, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t3_ignored_tv", bus.train_valid, 0);
    chk("t3_bc", bus.branch_cnt, 1);
    chk("t3_res_ready", bus.res_ready, 0);

    // Correct resolve and push together keep the count.
    rst_cyc();
    for (int i = 0; i < 4; i++) cyc(0, 1, 10 + i, 0, 0, 0, 0);
    cyc(0, 1, 14, 0, 5, 1, 0);
    chk("t4_pc", bus.train_pc, 10);
    chk("t4_mis", bus.train_mispredicted, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("t4_drain_pc", bus.train_pc, 11 + i);
    end
    chk("t4_last_hist", bus.train_history, 5);
    idle();
    chk("t4_empty", bus.res_ready, 0);

    // Mispredict with same-cycle push drops the push.
    rst_cyc();
    cyc(0, 1, 30, 1, 0, 0, 0);
    cyc(0, 1, 31, 1, 0, 0, 0);
    cyc(0, 1, 20, 1, 0, 1, 0);
    chk("t5_flush", bus.flush, 1);
    idle();
    chk("t5_empty", bus.res_ready, 0);

    // Reset with entries queued and a train pending.
    rst_cyc();
    for (int i = 0; i < 6; i++) cyc(0, 1, 40 + i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t6_pre_tv", bus.train_valid, 1);
    rst_cyc();
    chk("t6_tv", bus.train_valid, 0);
    chk("t6_br_ready", bus.br_ready, 1);
    chk("t6_res_ready", bus.res_ready, 0);
    chk("t6_bc", bus.branch_cnt, 0);
    chk("t6_mc", bus.mispred_cnt, 0);
    idle();
    chk("t6_no_train", bus.train_valid, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1 : 0,
          ($urandom_range(0, 9) < 6) ? 1 : 0,
          int'($urandom_range(0, 127)),
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 127)),
          ($urandom_range(0, 9) < 4) ? 1 : 0,
          ($urandom_range(0, 9) < 7) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
